// File: rtl/mem_stage_lsu.sv
// Registered MEM stage: ALU results pass through in one cycle, loads/stores run
// over a req/ack data port with lane steering, load extension and a timeout.
module mem_stage_lsu #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic [REG_AW-1:0]   wd_i,
    input  logic                wreg_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic [3:0]          mem_op_i,
    input  logic                mem_uns_i,
    input  logic [XLEN-1:0]     mem_addr_i,
    input  logic [XLEN-1:0]     mem_sdata_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    output logic                stall_o,
    output logic                valid_o,
    output logic [REG_AW-1:0]   wd_o,
    output logic                wreg_o,
    output logic [XLEN-1:0]     wdata_o,
    output logic                err_o,
    output logic                dbg_busy
);
    localparam int BW = XLEN / 8;
    localparam int LB = $clog2(BW);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    logic [TW-1:0]     tmo_cnt;
    logic [REG_AW-1:0] l_wd;
    logic              l_wreg;
    logic [XLEN-1:0]   l_wdata;
    logic              l_uns;
    logic              l_store;
    logic [1:0]        l_size;
    logic [LB-1:0]     l_lane;

    logic [LB-1:0]   lane;
    logic            misaligned;
    logic [BW-1:0]   be_base;
    logic            tmo_hit;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] load_data;

    assign lane     = mem_addr_i[LB-1:0];
    assign dbg_busy = (state == BUSY);
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST) && !mem_ack_i;
    assign rshift   = mem_rdata_i >> {l_lane, 3'b000};

    always_comb begin
        misaligned = 1'b0;
        be_base    = BW'(1);
        case (mem_op_i[1:0])
            2'b00: be_base = BW'(1);
            2'b01: begin
                be_base    = BW'(3);
                misaligned = mem_addr_i[0];
            end
            2'b10: begin
                be_base    = BW'(15);
                misaligned = (mem_addr_i[1:0] != 2'b00);
            end
            default: begin
                be_base    = {BW{1'b1}};
                misaligned = (XLEN == 32) || (mem_addr_i[2:0] != 3'b000);
            end
        endcase
    end

    // Sized casts of signed slices sign-extend; unsigned slices zero-extend.
    always_comb begin
        load_data = rshift;
        case (l_size)
            2'b00: load_data = l_uns ? XLEN'(rshift[7:0])  : XLEN'($signed(rshift[7:0]));
            2'b01: load_data = l_uns ? XLEN'(rshift[15:0]) : XLEN'($signed(rshift[15:0]));
            2'b10: load_data = l_uns ? XLEN'(rshift[31:0]) : XLEN'($signed(rshift[31:0]));
            default: load_data = rshift;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        if (state == IDLE)
            stall_o = valid_i && mem_op_i[3] && !misaligned;
        else
            stall_o = !mem_ack_i && !tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            valid_o     <= 1'b0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            wdata_o     <= '0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            l_wd        <= '0;
            l_wreg      <= 1'b0;
            l_wdata     <= '0;
            l_uns       <= 1'b0;
            l_store     <= 1'b0;
            l_size      <= 2'b00;
            l_lane      <= '0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    wreg_o <= 1'b0;
                    if (valid_i) begin
                        wd_o <= wd_i;
                        if (!mem_op_i[3]) begin
                            valid_o <= 1'b1;
                            wreg_o  <= wreg_i;
                            wdata_o <= wdata_i;
                        end else if (misaligned) begin
                            valid_o <= 1'b1;
                            err_o   <= 1'b1;
                        end else begin
                            state       <= BUSY;
                            tmo_cnt     <= '0;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= mem_op_i[2];
                            mem_addr_o  <= {mem_addr_i[XLEN-1:LB], {LB{1'b0}}};
                            mem_be_o    <= be_base << lane;
                            mem_wdata_o <= mem_sdata_i << {lane, 3'b000};
                            l_wd        <= wd_i;
                            l_wreg      <= wreg_i;
                            l_wdata     <= wdata_i;
                            l_uns       <= mem_uns_i;
                            l_store     <= mem_op_i[2];
                            l_size      <= mem_op_i[1:0];
                            l_lane      <= lane;
                        end
                    end
                end
                default: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        valid_o   <= 1'b1;
                        wreg_o    <= l_wreg;
                        wd_o      <= l_wd;
                        wdata_o   <= l_store ? l_wdata : load_data;
                    end else if (tmo_hit) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        valid_o   <= 1'b1;
                        wreg_o    <= 1'b0;
                        wd_o      <= l_wd;
                        err_o     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=32, TIMEOUT=4): expected writebacks and
// bus requests are queued at issue time and checked by independent monitors.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [3:0]  mem_op_i;
    logic        mem_uns_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        err_o;
    logic        dbg_busy;

    int checks   = 0;
    int failures = 0;

    // {check_data, err, wreg, wd[4:0], wdata[31:0]}
    logic [39:0] wb_q[$];
    // {we, addr[31:0], be[3:0], wdata[31:0]}
    logic [68:0] bus_q[$];

    mem_stage_lsu #(.XLEN(32), .REG_AW(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_uns_i(mem_uns_i),
        .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .err_o(err_o), .dbg_busy(dbg_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] mk_wb(input logic chkd, input logic err, input logic wreg,
                                          input logic [4:0] wd, input logic [31:0] data);
        return {chkd, err, wreg, wd, data};
    endfunction

    function automatic logic [68:0] mk_bus(input logic we, input logic [31:0] addr,
                                           input logic [3:0] be, input logic [31:0] data);
        return {we, addr, be, data};
    endfunction

    // Writeback monitor
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 128'(valid_o), 128'(0));
            end else begin
                logic [39:0] e;
                e = wb_q.pop_front();
                chk("wb", {err_o, wreg_o, wd_o, (e[39] ? wdata_o : 32'h0)},
                          {e[38], e[37], e[36:32], (e[39] ? e[31:0] : 32'h0)});
            end
        end else if (!rst) begin
            chk("err_idle", 128'(err_o), 128'(0));
        end
    end

    // Bus monitor: the request is popped on its rising cycle and must hold until it drops
    logic        prev_req = 1'b0;
    logic [68:0] cur_bus  = '0;
    always @(negedge clk) begin
        if (!rst && mem_req_o) begin
            if (!prev_req) begin
                if (bus_q.size() == 0) chk("bus_unexpected", 128'(mem_req_o), 128'(0));
                else cur_bus = bus_q.pop_front();
            end
            chk("bus", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, cur_bus);
        end
        prev_req = mem_req_o;
    end

    // Issue one instruction; busy = expected BUSY cycles (0 for ALU/misaligned),
    // ack_at = BUSY cycle index carrying the ack (-1: never).
    task automatic run_op(input string name, input logic [3:0] op, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input int busy, input int ack_at, input logic [31:0] rdata,
                          input logic [39:0] exp_wb, input logic [68:0] exp_bus);
        int stall_cnt;
        int req_cnt;
        valid_i = 1'b1; mem_op_i = op; mem_uns_i = uns; mem_addr_i = addr;
        mem_sdata_i = sdata; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
        wb_q.push_back(exp_wb);
        if (busy > 0) bus_q.push_back(exp_bus);
        #1;
        stall_cnt = int'(stall_o);
        req_cnt = 0;
        @(negedge clk);
        for (int k = 0; k < busy; k++) begin
            if (k == ack_at) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = rdata;
            end
            #1;
            stall_cnt += int'(stall_o);
            req_cnt += int'(mem_req_o);
            @(negedge clk);
            mem_ack_i = 1'b0;
            mem_rdata_i = 32'hA5A5_A5A5;
        end
        valid_i = 1'b0;
        chk({name, "_stall_cycles"}, 128'(stall_cnt), 128'(busy));
        chk({name, "_req_cycles"}, 128'(req_cnt), 128'(busy));
        chk({name, "_latency"}, 128'(valid_o), 128'(1));
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        mem_op_i = '0; mem_uns_i = 1'b0; mem_addr_i = '0; mem_sdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'hA5A5_A5A5;
        repeat (3) @(negedge clk);
        chk("reset_state", {valid_o, wd_o, wreg_o, wdata_o, err_o, mem_req_o, mem_we_o,
                            mem_addr_o, mem_be_o, mem_wdata_o, stall_o, dbg_busy}, 128'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op("alu", 4'b0000, 0, 32'h0, 32'h0, 5'd5, 1, 32'h1234, 0, -1, 0,
               mk_wb(1, 0, 1, 5'd5, 32'h1234), '0);
        run_op("lb_s", 4'b1000, 0, 32'h1003, 32'h0, 5'd7, 1, 32'hDEAD, 3, 2, 32'h8012_3456,
               mk_wb(1, 0, 1, 5'd7, 32'hFFFF_FF80), mk_bus(0, 32'h1000, 4'h8, 32'h0));
        run_op("lb_u", 4'b1000, 1, 32'h1003, 32'h0, 5'd7, 1, 32'hDEAD, 3, 2, 32'h8012_3456,
               mk_wb(1, 0, 1, 5'd7, 32'h0000_0080), mk_bus(0, 32'h1000, 4'h8, 32'h0));
        run_op("lb_lane1", 4'b1000, 0, 32'h1001, 32'h0, 5'd10, 1, 32'h0, 1, 0, 32'h0000_FE00,
               mk_wb(1, 0, 1, 5'd10, 32'hFFFF_FFFE), mk_bus(0, 32'h1000, 4'h2, 32'h0));
        run_op("sh", 4'b1101, 0, 32'h2002, 32'hBEEF, 5'd3, 0, 32'h55, 1, 0, 32'h0,
               mk_wb(1, 0, 0, 5'd3, 32'h55), mk_bus(1, 32'h2000, 4'hC, 32'hBEEF_0000));
        run_op("lw_misal", 4'b1010, 0, 32'h3001, 32'h0, 5'd4, 1, 32'h0, 0, -1, 0,
               mk_wb(0, 1, 0, 5'd4, 32'h0), '0);
        run_op("lw_timeout", 4'b1010, 0, 32'h4000, 32'h0, 5'd6, 1, 32'h0, 4, -1, 0,
               mk_wb(0, 1, 0, 5'd6, 32'h0), mk_bus(0, 32'h4000, 4'hF, 32'h0));
        run_op("lw_ack_last", 4'b1010, 0, 32'h4004, 32'h0, 5'd8, 1, 32'h0, 4, 3, 32'hCAFE_F00D,
               mk_wb(1, 0, 1, 5'd8, 32'hCAFE_F00D), mk_bus(0, 32'h4004, 4'hF, 32'h0));
        run_op("lh_s", 4'b1001, 0, 32'h5002, 32'h0, 5'd9, 1, 32'h0, 2, 1, 32'h9ABC_1234,
               mk_wb(1, 0, 1, 5'd9, 32'hFFFF_9ABC), mk_bus(0, 32'h5000, 4'hC, 32'h0));
        run_op("lh_u", 4'b1001, 1, 32'h5002, 32'h0, 5'd9, 1, 32'h0, 2, 1, 32'h9ABC_1234,
               mk_wb(1, 0, 1, 5'd9, 32'h0000_9ABC), mk_bus(0, 32'h5000, 4'hC, 32'h0));
        run_op("lb_pos", 4'b1000, 0, 32'h5000, 32'h0, 5'd11, 1, 32'h0, 1, 0, 32'h1234_567F,
               mk_wb(1, 0, 1, 5'd11, 32'h0000_007F), mk_bus(0, 32'h5000, 4'h1, 32'h0));
        run_op("sb", 4'b1100, 0, 32'h6001, 32'h1234_56A5, 5'd12, 0, 32'h66, 1, 0, 32'h0,
               mk_wb(1, 0, 0, 5'd12, 32'h66), mk_bus(1, 32'h6000, 4'h2, 32'h3456_A500));
        run_op("sw", 4'b1110, 0, 32'h7000, 32'hDEAD_BEEF, 5'd13, 1, 32'h77, 3, 2, 32'h0,
               mk_wb(1, 0, 1, 5'd13, 32'h77), mk_bus(1, 32'h7000, 4'hF, 32'hDEAD_BEEF));
        run_op("ld_rv32", 4'b1011, 0, 32'h8000, 32'h0, 5'd14, 1, 32'h0, 0, -1, 0,
               mk_wb(0, 1, 0, 5'd14, 32'h0), '0);
        run_op("sh_misal", 4'b1101, 0, 32'h9001, 32'h1, 5'd15, 0, 32'h0, 0, -1, 0,
               mk_wb(0, 1, 0, 5'd15, 32'h0), '0);
        run_op("alu_nowreg", 4'b0000, 0, 32'h0, 32'h0, 5'd2, 0, 32'h77, 0, -1, 0,
               mk_wb(1, 0, 0, 5'd2, 32'h77), '0);

        // Reset while BUSY: request drops, a late ack is ignored, next op is clean
        valid_i = 1'b1; mem_op_i = 4'b1010; mem_uns_i = 1'b0; mem_addr_i = 32'hA000;
        mem_sdata_i = '0; wd_i = 5'd16; wreg_i = 1'b1;
        bus_q.push_back(mk_bus(0, 32'hA000, 4'hF, 32'h0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", {valid_o, wd_o, wreg_o, wdata_o, err_o, mem_req_o, mem_we_o,
                           mem_addr_o, mem_be_o, mem_wdata_o, stall_o, dbg_busy}, 128'(0));
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h1111_1111;
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("late_ack_ignored", {valid_o, mem_req_o, dbg_busy}, 128'(0));
        run_op("alu_after_rst", 4'b0000, 0, 32'h0, 32'h0, 5'd9, 1, 32'hABCD, 0, -1, 0,
               mk_wb(1, 0, 1, 5'd9, 32'hABCD), '0);

        repeat (3) @(negedge clk);
        chk("wb_queue_empty", 128'(wb_q.size()), 128'(0));
        chk("bus_queue_empty", 128'(bus_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised MEM pipeline stage for the RISC-V core. Replaces the combinational pass-through with a registered stage that also performs loads and stores over a req/ack data-memory port.
- Non-memory instructions pass through with 1-cycle latency.
- Memory instructions stall the pipeline until the memory acknowledges or a timeout fires.
- Loads are byte-lane extracted and sign- or zero-extended before writeback.

Parameters:
- XLEN, 32, data width; must be 32 or 64.
- REG_AW, 5, register address width.
- TIMEOUT, 16, maximum cycles waiting for mem_ack_i; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_i  in  1  instruction present from EX/MEM register
- wd_i  in  REG_AW  destination register
- wreg_i  in  1  register-write enable
- wdata_i  in  XLEN  ALU result (non-load writeback data)
- mem_op_i  in  4  [3] memory op, [2] store(1)/load(0), [1:0] size: 00 B, 01 H, 10 W, 11 D
- mem_uns_i  in  1  load zero-extend
- mem_addr_i  in  XLEN  effective address
- mem_sdata_i  in  XLEN  store data, right-aligned
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write strobe
- mem_addr_o  out  XLEN  address, lane bits forced to 0
- mem_be_o  out  XLEN/8  byte enables
- mem_wdata_o  out  XLEN  lane-shifted store data
- mem_ack_i  in  1  request complete, rdata valid
- mem_rdata_i  in  XLEN  read data
- stall_o  out  1  hold upstream stages
- valid_o  out  1  writeback valid
- wd_o  out  REG_AW  writeback register
- wreg_o  out  1  writeback enable
- wdata_o  out  XLEN  writeback data
- err_o  out  1  one-cycle pulse on misaligned access or timeout

Behaviour:
- Reset is synchronous, active-high on rst (rst=1 at a clk rising edge). All registered outputs clear: valid_o, wd_o, wreg_o, wdata_o, err_o, mem_req_o, mem_we_o = 0. FSM returns to IDLE and the timeout counter clears. Reset mid-transaction drops mem_req_o on the next edge, and a late ack is ignored.
- Lane bits are addr[LB-1:0], where LB = log2(XLEN/8).
- Misaligned means any of:
  - H with addr[0] set;
  - W with addr[1:0] not 0;
  - D with addr[2:0] not 0;
  - D when XLEN = 32.
- FSM states are IDLE and BUSY.
- IDLE, valid_i = 0: next edge valid_o = 0, wreg_o = 0.
- IDLE, valid_i with mem_op_i[3] = 0: next edge valid_o = 1; wd_o, wreg_o, wdata_o copy the inputs. stall_o = 0.
- IDLE, misaligned memory op: no request is issued. Next edge valid_o = 1, wreg_o = 0, err_o = 1 for one cycle. stall_o = 0.
- IDLE, aligned memory op:
  - stall_o = 1 combinationally.
  - Next edge: go to BUSY; mem_req_o = 1; drive mem_we_o, mem_addr_o and mem_be_o.
  - mem_wdata_o = mem_sdata_i shifted left by 8 × lane.
  - Byte enables: B sets 1 bit, H 2 bits, W 4 bits, D 8 bits, all shifted left by the lane.
- BUSY: mem_req_o and all bus outputs stay constant until the ack. Upstream holds its inputs stable while stall_o = 1. stall_o = !mem_ack_i.
- BUSY with mem_ack_i (sampled at edge):
  - Load: wdata_o = mem_rdata_i shifted right by 8 × lane, then truncated to the access size. Sign-extended unless mem_uns_i = 1 (W is zero-extended to 64 only when uns).
  - Store: wdata_o = wdata_i.
  - valid_o = 1, wreg_o = wreg_i, wd_o = wd_i, mem_req_o = 0, return to IDLE.
  - Total latency is 1 + ack wait cycles. A mem_ack_i in the same cycle mem_req_o first rises counts (minimum 2 cycles).
- Timeout:
  - The counter increments every BUSY cycle without an ack.
  - When the counter reaches TIMEOUT − 1 and there is no ack: mem_req_o = 0, err_o = 1, valid_o = 1, wreg_o = 0, back to IDLE, stall_o = 0 in that cycle.
  - An ack arriving in that same cycle wins; no error is raised.
- mem_ack_i while in IDLE is ignored.
- Back-to-back memory ops: the first memory access and the IDLE accept of the next are 1 cycle apart, because of the IDLE→BUSY registration.
- valid_o is high for exactly one cycle per accepted instruction.

Test Plan:
- ALU pass-through: valid_i = 1, op = 0, wd = 5, wdata = 0x1234 → next cycle valid_o = 1, wd_o = 5, wdata_o = 0x1234, stall_o never high.
- Signed byte load: addr = 0x1003, LB signed, ack after 2 cycles with rdata = 0x80xxxxxx → be = 0x8, wdata_o = 0xFFFFFF80, stall_o high for 3 cycles. Repeat with uns = 1 → 0x00000080.
- Half store: addr = 0x2002, sdata = 0xBEEF → mem_be_o = 0xC, mem_wdata_o = 0xBEEF0000, mem_addr_o = 0x2000, mem_we_o = 1 until ack.
- Misaligned word load at 0x3001 → no mem_req_o, err_o pulse, wreg_o = 0, no stall.
- TIMEOUT = 4, ack never asserted → mem_req_o high 4 cycles, then err_o = 1, stall released. Variant with ack in the 4th cycle → normal completion, no err.
- rst asserted during BUSY → next edge mem_req_o = 0, all outputs 0, FSM IDLE. Subsequent ALU op completes normally.
